conv_out_sequencer: RTL and testbench

- Sequencing controller for the parallel X(128)/F(32) convolution datapath: a multiplier register stage followed by four adder-tree register stages.
- Once both X and F memories report full, it steps the X window offset across all valid positions and drives the single pipeline enable.
- It tracks which pipeline slots hold real data, presents results to the output AXI-stream handshake with backpressure, and emits a one-cycle completion pulse that clears the input memory controllers.

---
 rtl/conv_out_sequencer.sv | 134 +++++++++++++
 tb/tb_conv_out_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_out_sequencer
// Purpose  : Sequencer for the X/F convolution datapath. It walks the X window
//            offset, drives the shared pipeline enable, tracks which pipeline
//            slots hold real data, handshakes results out over AXI-stream and
//            pulses conv_done after the final result is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module conv_out_sequencer #(
    parameter int X_SIZE           = 128,
    parameter int F_SIZE           = 32,
    parameter int PLINE_STAGES     = 5,
    parameter int X_MEM_ADDR_WIDTH = $clog2(X_SIZE),
    parameter int OUT_CNT_WIDTH    = $clog2(X_SIZE - F_SIZE + 2)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        conv_start,
    input  logic                        m_ready_y,
    output logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
    output logic                        en_pline_stages,
    output logic                        m_valid_y,
    output logic                        conv_done,
    output logic                        busy
);

    // Outputs per convolution and derived compare values
    localparam int N = X_SIZE - F_SIZE + 1;
    localparam logic [OUT_CNT_WIDTH-1:0]    C_N        = OUT_CNT_WIDTH'(N);
    localparam logic [OUT_CNT_WIDTH-1:0]    C_N_M1     = OUT_CNT_WIDTH'(N - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] C_XADDR_MAX = X_MEM_ADDR_WIDTH'(X_SIZE - F_SIZE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_DONE     = 2'd2,
        S_WAIT_CLR = 2'd3
    } state_t;

    state_t                      state_q;
    logic [PLINE_STAGES-1:0]     vs_q;
    logic [PLINE_STAGES-1:0]     vs_d;
    logic [OUT_CNT_WIDTH-1:0]    issued_cnt_q;
    logic [OUT_CNT_WIDTH-1:0]    out_cnt_q;
    logic [X_MEM_ADDR_WIDTH-1:0] xaddr_q;

    logic in_run;
    logic stall;
    logic issue;
    logic accept;

    // Handshake and enable decode; valid comes only from registered state so
    // it never depends combinationally on m_ready_y.
    assign in_run = (state_q == S_RUN);
    assign stall  = vs_q[PLINE_STAGES-1] & ~m_ready_y;
    assign issue  = en_pline_stages & (issued_cnt_q < C_N);
    assign accept = m_valid_y & m_ready_y;
    assign vs_d   = {vs_q[PLINE_STAGES-2:0], issue};

    assign en_pline_stages = in_run & ~stall;
    assign m_valid_y       = in_run & vs_q[PLINE_STAGES-1];
    assign conv_done       = (state_q == S_DONE);
    assign busy            = in_run | (state_q == S_DONE);
    assign load_xaddr_val  = xaddr_q;

    // Control FSM with issue/output counters and slot-valid shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vs_q         <= '0;
            issued_cnt_q <= '0;
            out_cnt_q    <= '0;
            xaddr_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (conv_start) begin
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!conv_start) begin
                        // Abort: memories no longer full, drop everything quietly
                        state_q      <= S_IDLE;
                        vs_q         <= '0;
                        issued_cnt_q <= '0;
                        out_cnt_q    <= '0;
                        xaddr_q      <= '0;
                    end else begin
                        if (en_pline_stages) begin
                            vs_q <= vs_d;
                        end
                        if (issue) begin
                            issued_cnt_q <= issued_cnt_q + 1'b1;
                            // Offset stops at the last valid window position
                            if ((issued_cnt_q < C_N_M1) && (xaddr_q < C_XADDR_MAX)) begin
                                xaddr_q <= xaddr_q + 1'b1;
                            end
                        end
                        if (accept) begin
                            out_cnt_q <= out_cnt_q + 1'b1;
                            if (out_cnt_q == C_N_M1) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q      <= S_WAIT_CLR;
                    vs_q         <= '0;
                    issued_cnt_q <= '0;
                    out_cnt_q    <= '0;
                    xaddr_q      <= '0;
                end

                S_WAIT_CLR: begin
                    // Hold off until the stale "memories full" level is gone
                    if (!conv_start) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_out_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_out_sequencer
// Purpose  : Directed self-checking bench for conv_out_sequencer. A local
//            5-stage model of the datapath carries load_xaddr_val under
//            en_pline_stages so each accepted output can be checked against
//            its expected offset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_out_sequencer;

    localparam int P = 5;
    localparam int N = 97;

    logic       clk = 1'b0;
    logic       reset;
    logic       conv_start;
    logic       m_ready_y;
    logic [6:0] load_xaddr_val;
    logic       en_pline_stages;
    logic       m_valid_y;
    logic       conv_done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int rise_cyc = 0;
    int ord_base = 0;
    logic prev_valid = 1'b0;
    int pipe [P] = '{default: 0};

    conv_out_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .conv_start      (conv_start),
        .m_ready_y       (m_ready_y),
        .load_xaddr_val  (load_xaddr_val),
        .en_pline_stages (en_pline_stages),
        .m_valid_y       (m_valid_y),
        .conv_done       (conv_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: handshakes, valid rise, done pulses, datapath model
    always @(negedge clk) begin
        if (m_valid_y && m_ready_y) begin
            check("order", pipe[P-1], hs_cnt - ord_base);
            hs_cnt      <= hs_cnt + 1;
            last_hs_cyc <= cyc;
        end
        if (m_valid_y && !prev_valid) rise_cyc <= cyc;
        prev_valid <= m_valid_y;
        if (conv_done) done_cnt <= done_cnt + 1;
        if (en_pline_stages) begin
            pipe[0] <= int'(load_xaddr_val);
            for (int k = 1; k < P; k++) pipe[k] <= pipe[k-1];
        end
    end

    // One full convolution. mode 0: ready=1, 1: random ready, 2: 10-cycle stall after 3 outputs
    task automatic run_conv(input int mode, input int exp_lat);
        int t;
        int maxa;
        int d0;
        int stall_left;
        bit stalled;
        bit found;
        ord_base   = hs_cnt;
        d0         = done_cnt;
        maxa       = 0;
        stalled    = 1'b0;
        stall_left = 0;
        found      = 1'b0;
        conv_start = 1'b1;
        m_ready_y  = 1'b1;
        step();
        t = cyc;
        check("run_busy", busy, 1);
        check("run_addr0", load_xaddr_val, 0);
        for (int i = 0; i < 600; i++) begin
            step();
            if (conv_done) begin
                found = 1'b1;
                break;
            end
            if (int'(load_xaddr_val) > maxa) maxa = int'(load_xaddr_val);
            if (mode == 1) begin
                m_ready_y = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (!stalled && (hs_cnt - ord_base) == 3) begin
                    stalled    = 1'b1;
                    stall_left = 10;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    m_ready_y = 1'b0;
                    #1;
                    check("stall_en", en_pline_stages, 0);
                    check("stall_valid", m_valid_y, 1);
                    check("stall_addr", load_xaddr_val, 8);
                end else begin
                    m_ready_y = 1'b1;
                end
            end
        end
        m_ready_y = 1'b1;
        check("done_seen", found, 1);
        if (exp_lat >= 0) check("done_lat", cyc - t, exp_lat);
        check("hs_total", hs_cnt - ord_base, N);
        check("first_valid_lat", rise_cyc - t, P);
        check("done_after_last_hs", cyc - last_hs_cyc, 1);
        check("max_addr", maxa, 96);
        step();
        check("post_done_pulse", conv_done, 0);
        check("post_done_busy", busy, 0);
        check("done_pulses", done_cnt - d0, 1);
    endtask

    // Start a run and return once n outputs have been accepted
    task automatic start_partial(input int n);
        bit found;
        found      = 1'b0;
        ord_base   = hs_cnt;
        conv_start = 1'b1;
        m_ready_y  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if ((hs_cnt - ord_base) >= n) begin
                found = 1'b1;
                break;
            end
        end
        check("partial_reach", found, 1);
    endtask

    initial begin
        int d0;
        reset      = 1'b1;
        conv_start = 1'b0;
        m_ready_y  = 1'b0;
        repeat (3) step();
        check("rst_addr", load_xaddr_val, 0);
        check("rst_en", en_pline_stages, 0);
        check("rst_valid", m_valid_y, 0);
        check("rst_done", conv_done, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();
        check("idle_en", en_pline_stages, 0);

        // Full run with continuous ready, then hold conv_start after done
        run_conv(0, 102);
        repeat (3) begin
            step();
            check("wclr_busy", busy, 0);
            check("wclr_valid", m_valid_y, 0);
            check("wclr_en", en_pline_stages, 0);
            check("wclr_addr", load_xaddr_val, 0);
        end
        conv_start = 1'b0;
        step();
        step();
        check("idle_after_clr", busy, 0);

        // Second run must match the first
        run_conv(0, 102);
        conv_start = 1'b0;
        step();
        step();

        // Backpressure: 10 cycles of ready low after 3 outputs
        run_conv(2, 112);
        conv_start = 1'b0;
        step();
        step();

        // Random ready
        run_conv(1, -1);
        conv_start = 1'b0;
        step();
        step();

        // Abort by dropping conv_start mid-run
        start_partial(20);
        d0 = done_cnt;
        conv_start = 1'b0;
        step();
        check("abort_valid", m_valid_y, 0);
        check("abort_busy", busy, 0);
        check("abort_en", en_pline_stages, 0);
        check("abort_addr", load_xaddr_val, 0);
        repeat (3) step();
        check("abort_no_done", done_cnt - d0, 0);

        // Reset at output 40, then a fresh run from offset 0
        start_partial(40);
        d0 = done_cnt;
        reset      = 1'b1;
        conv_start = 1'b0;
        step();
        check("mrst_valid", m_valid_y, 0);
        check("mrst_busy", busy, 0);
        check("mrst_en", en_pline_stages, 0);
        check("mrst_addr", load_xaddr_val, 0);
        check("mrst_done", conv_done, 0);
        reset = 1'b0;
        repeat (3) step();
        check("mrst_no_done", done_cnt - d0, 0);
        run_conv(0, 102);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
